// File: rtl/kmac_ascon_pkg.sv
// Shared types for the KMAC/Ascon sequencer: FSM state codes, request modes
// and the default engine-response timeout.
package kmac_ascon_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KMAC_RUN   = 3'd1,
        ST_CHAIN_FEED = 3'd2,
        ST_HASH_FEED  = 3'd3,
        ST_HASH_WAIT  = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_KMAC  = 2'd0,
        MODE_HASH  = 2'd1,
        MODE_CHAIN = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

endpackage

// File: rtl/kmac_ascon_word_ser.sv
// Splits a captured KMAC tag into WORD_BITS words, lowest word first, one per
// cycle while active, flagging the first and last word.
module kmac_ascon_word_ser #(
    parameter int DIGEST_BITS = 256,
    parameter int WORD_BITS   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   active,
    input  logic [DIGEST_BITS-1:0] mac,
    output logic [WORD_BITS-1:0]   word,
    output logic                   word_first,
    output logic                   word_last
);

    localparam int NW = DIGEST_BITS / WORD_BITS;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    logic [IW-1:0] idx_q;

    assign word_first = (idx_q == '0);
    assign word_last  = (idx_q == LAST_IDX);

    if (NW == 1) begin : g_single
        assign word = mac[WORD_BITS-1:0];
    end else begin : g_multi
        logic [NW-1:0][WORD_BITS-1:0] words;
        assign words = mac;
        assign word  = words[idx_q];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (active && !word_last) begin
            idx_q <= idx_q + 1'b1;
        end else begin
            idx_q <= '0;
        end
    end

endmodule

// File: rtl/kmac_ascon_seq.sv
// Sequences KMAC, Ascon-hash and KMAC-then-hash (chain) operations over
// external engines, with a response timeout and single-cycle status pulses.
module kmac_ascon_seq
    import kmac_ascon_pkg::*;
#(
    parameter int          DIGEST_BITS    = 256,
    parameter int          WORD_BITS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_mode,
    output logic                   kmac_start,
    input  logic                   kmac_done,
    input  logic [DIGEST_BITS-1:0] kmac_mac,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [WORD_BITS-1:0]   host_data,
    input  logic                   host_last,
    output logic                   hash_msg_valid,
    output logic                   hash_msg_start,
    output logic                   hash_msg_last,
    output logic [WORD_BITS-1:0]   hash_msg,
    input  logic                   hash_ready,
    output logic [DIGEST_BITS-1:0] mac_out,
    output logic                   op_done,
    output logic                   op_err,
    output logic                   busy,
    output logic [2:0]             top_state
);

    if ((DIGEST_BITS % WORD_BITS) != 0 || DIGEST_BITS < WORD_BITS) begin : g_bad_params
        $error("DIGEST_BITS must be a nonzero multiple of WORD_BITS");
    end

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_n;
    mode_e                mode_q;
    logic [31:0]          cnt_q;
    logic                 timeout;
    logic                 start_n, err_n, done_n;
    logic                 first_q;
    logic                 fwd_valid_q, fwd_start_q, fwd_last_q;
    logic [WORD_BITS-1:0] fwd_data_q;
    logic                 chain_act;
    logic [WORD_BITS-1:0] ser_word;
    logic                 ser_first, ser_last;

    assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign chain_act = (state_q == ST_CHAIN_FEED);

    kmac_ascon_word_ser #(
        .DIGEST_BITS (DIGEST_BITS),
        .WORD_BITS   (WORD_BITS)
    ) u_word_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (chain_act),
        .mac        (mac_out),
        .word       (ser_word),
        .word_first (ser_first),
        .word_last  (ser_last)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state_q;
        start_n = 1'b0;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (mode_e'(req_mode))
                        MODE_RSVD: err_n   = 1'b1;
                        MODE_HASH: state_n = ST_HASH_FEED;
                        default: begin
                            start_n = 1'b1;
                            state_n = ST_KMAC_RUN;
                        end
                    endcase
                end
            end
            // A response on the same cycle as the timeout takes priority.
            ST_KMAC_RUN: begin
                if (kmac_done) begin
                    state_n = (mode_q == MODE_CHAIN) ? ST_CHAIN_FEED : ST_DONE;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CHAIN_FEED: if (ser_last) state_n = ST_HASH_WAIT;
            ST_HASH_FEED:  if (host_valid && host_last) state_n = ST_HASH_WAIT;
            ST_HASH_WAIT: begin
                if (hash_ready) begin
                    state_n = ST_DONE;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_KMAC;
            cnt_q       <= '0;
            kmac_start  <= 1'b0;
            op_err      <= 1'b0;
            op_done     <= 1'b0;
            mac_out     <= '0;
            first_q     <= 1'b1;
            fwd_valid_q <= 1'b0;
            fwd_start_q <= 1'b0;
            fwd_last_q  <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q    <= state_n;
            kmac_start <= start_n;
            op_err     <= err_n;
            op_done    <= done_n;
            if (state_q == ST_IDLE && req_valid) mode_q <= mode_e'(req_mode);
            if (state_n != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_KMAC_RUN || state_q == ST_HASH_WAIT) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (state_q == ST_KMAC_RUN && kmac_done) mac_out <= kmac_mac;
            // Host words are forwarded through one register stage.
            if (state_q == ST_HASH_FEED && host_valid) begin
                fwd_valid_q <= 1'b1;
                fwd_start_q <= first_q;
                fwd_last_q  <= host_last;
                fwd_data_q  <= host_data;
                first_q     <= 1'b0;
            end else begin
                fwd_valid_q <= 1'b0;
                fwd_start_q <= 1'b0;
                fwd_last_q  <= 1'b0;
                if (state_q == ST_IDLE) first_q <= 1'b1;
            end
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign host_ready     = (state_q == ST_HASH_FEED);
    assign busy           = (state_q != ST_IDLE);
    assign top_state      = state_q;
    assign hash_msg_valid = chain_act | fwd_valid_q;
    assign hash_msg_start = chain_act ? ser_first : fwd_start_q;
    assign hash_msg_last  = chain_act ? ser_last  : fwd_last_q;
    assign hash_msg       = chain_act ? ser_word  : fwd_data_q;

endmodule

// File: tb/tb_kmac_ascon_seq.sv
// Directed bench for kmac_ascon_seq: a 256/64 instance with a short timeout
// and a 64/64 instance for the single-word chain case, sharing stimulus.
module tb_kmac_ascon_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, kmac_done, host_valid, host_last, hash_ready;
    logic [1:0]   req_mode;
    logic [255:0] kmac_mac;
    logic [63:0]  host_data;

    logic         req_ready, kmac_start, host_ready, op_done, op_err, busy;
    logic         hash_msg_valid, hash_msg_start, hash_msg_last;
    logic [63:0]  hash_msg;
    logic [255:0] mac_out;
    logic [2:0]   top_state;

    logic         b_req_ready, b_kmac_start, b_host_ready, b_op_done, b_op_err, b_busy;
    logic         b_hash_msg_valid, b_hash_msg_start, b_hash_msg_last;
    logic [63:0]  b_hash_msg, b_mac_out;
    logic [2:0]   b_top_state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] MAC_A5    = {32{8'hA5}};
    localparam logic [255:0] MAC_CHAIN = {64'h4, 64'h3, 64'h2, 64'h1};
    localparam logic [255:0] MAC_ONES  = '1;

    always #5 clk = ~clk;

    kmac_ascon_seq #(.DIGEST_BITS(256), .WORD_BITS(64), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .kmac_start(kmac_start), .kmac_done(kmac_done), .kmac_mac(kmac_mac),
        .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
        .host_last(host_last),
        .hash_msg_valid(hash_msg_valid), .hash_msg_start(hash_msg_start),
        .hash_msg_last(hash_msg_last), .hash_msg(hash_msg), .hash_ready(hash_ready),
        .mac_out(mac_out), .op_done(op_done), .op_err(op_err), .busy(busy),
        .top_state(top_state)
    );

    kmac_ascon_seq #(.DIGEST_BITS(64), .WORD_BITS(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_mode(req_mode),
        .kmac_start(b_kmac_start), .kmac_done(kmac_done), .kmac_mac(kmac_mac[63:0]),
        .host_valid(host_valid), .host_ready(b_host_ready), .host_data(host_data),
        .host_last(host_last),
        .hash_msg_valid(b_hash_msg_valid), .hash_msg_start(b_hash_msg_start),
        .hash_msg_last(b_hash_msg_last), .hash_msg(b_hash_msg), .hash_ready(hash_ready),
        .mac_out(b_mac_out), .op_done(b_op_done), .op_err(b_op_err), .busy(b_busy),
        .top_state(b_top_state)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one request for a single cycle; returns in the cycle after acceptance.
    task automatic request(input logic [1:0] mode);
        req_valid = 1'b1;
        req_mode  = mode;
        tick();
        req_valid = 1'b0;
    endtask

    // {req_ready, busy, kmac_start, op_done, op_err, host_ready, valid, start, last}
    function automatic logic [8:0] flags();
        return {req_ready, busy, kmac_start, op_done, op_err, host_ready,
                hash_msg_valid, hash_msg_start, hash_msg_last};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'd0; kmac_done = 1'b0;
        kmac_mac = '0; host_valid = 1'b0; host_last = 1'b0; host_data = '0;
        hash_ready = 1'b0;

        // Reset values
        tick();
        check("rst_flags", flags(), 9'b100000000);
        check("rst_state", top_state, 3'd0);
        check("rst_mac", mac_out, 256'h0);
        check("rst_msg", hash_msg, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // KMAC: done 10 cycles after kmac_start, op_done 2 cycles after done
        request(2'd0);
        check("kmac_start", kmac_start, 1'b1);
        check("kmac_state", top_state, 3'd1);
        tick();
        check("kmac_start_1cyc", kmac_start, 1'b0);
        repeat (9) tick();
        check("kmac_wait_state", top_state, 3'd1);
        kmac_done = 1'b1; kmac_mac = MAC_A5;
        tick();
        kmac_done = 1'b0;
        check("kmac_done_state", top_state, 3'd5);
        check("kmac_mac_out", mac_out, MAC_A5);
        check("kmac_op_done_early", op_done, 1'b0);
        tick();
        check("kmac_op_done", op_done, 1'b1);
        check("kmac_idle", top_state, 3'd0);
        tick();
        check("kmac_op_done_1cyc", op_done, 1'b0);

        // CHAIN: four words 1..4, start on first, last on fourth
        request(2'd2);
        check("chain_start", kmac_start, 1'b1);
        kmac_done = 1'b1; kmac_mac = MAC_CHAIN;
        tick();
        kmac_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("chain_state%0d", k), top_state, 3'd2);
            check($sformatf("chain_word%0d", k), {hash_msg_valid, hash_msg},
                  {1'b1, 64'(k + 1)});
            check($sformatf("chain_flags%0d", k), {hash_msg_start, hash_msg_last},
                  {k == 0, k == 3});
            tick();
        end
        check("chain_wait", top_state, 3'd4);
        check("chain_idle_flags", {hash_msg_valid, hash_msg_start, hash_msg_last}, 3'b000);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check("chain_done_state", top_state, 3'd5);
        tick();
        check("chain_op_done", op_done, 1'b1);
        check("chain_mac_out", mac_out, MAC_CHAIN);

        // HASH: 0x11 then gap then 0x22 (last)
        request(2'd1);
        check("hash_state", top_state, 3'd3);
        check("hash_host_ready", host_ready, 1'b1);
        host_valid = 1'b1; host_data = 64'h11; host_last = 1'b0;
        tick();
        host_valid = 1'b0;
        check("hash_w0", {hash_msg_valid, hash_msg_start, hash_msg_last, hash_msg},
              {3'b110, 64'h11});
        tick();
        check("hash_gap", {hash_msg_valid, hash_msg_start, hash_msg_last}, 3'b000);
        host_valid = 1'b1; host_data = 64'h22; host_last = 1'b1;
        tick();
        host_valid = 1'b0; host_last = 1'b0;
        check("hash_w1", {hash_msg_valid, hash_msg_start, hash_msg_last, hash_msg},
              {3'b101, 64'h22});
        check("hash_ready_drop", host_ready, 1'b0);
        check("hash_wait", top_state, 3'd4);
        tick();
        check("hash_after_last", hash_msg_valid, 1'b0);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check("hash_done_state", top_state, 3'd5);
        tick();
        check("hash_op_done", op_done, 1'b1);
        check("hash_mac_hold", mac_out, MAC_CHAIN);

        // Stray responses in IDLE are ignored
        kmac_done = 1'b1; kmac_mac = MAC_ONES; hash_ready = 1'b1;
        tick();
        kmac_done = 1'b0; hash_ready = 1'b0;
        check("stray_idle_state", top_state, 3'd0);
        check("stray_idle_mac", mac_out, MAC_CHAIN);

        // Timeout: 16 cycles in KMAC_RUN, then op_err and IDLE
        request(2'd0);
        check("to_start", kmac_start, 1'b1);
        repeat (15) tick();
        check("to_still_run", {top_state, op_err}, {3'd1, 1'b0});
        tick();
        check("to_op_err", op_err, 1'b1);
        check("to_idle", top_state, 3'd0);
        check("to_mac_hold", mac_out, MAC_CHAIN);
        tick();
        check("to_op_err_1cyc", op_err, 1'b0);
        kmac_done = 1'b1;
        tick();
        kmac_done = 1'b0;
        check("to_stray_state", top_state, 3'd0);
        check("to_stray_mac", mac_out, MAC_CHAIN);
        tick();
        check("to_stray_done", op_done, 1'b0);

        // Reserved mode
        request(2'd3);
        check("rsvd_err", {op_err, kmac_start, req_ready}, 3'b101);
        check("rsvd_state", top_state, 3'd0);
        tick();
        check("rsvd_err_1cyc", op_err, 1'b0);

        // Reset in the middle of CHAIN_FEED
        request(2'd2);
        kmac_done = 1'b1; kmac_mac = MAC_CHAIN;
        tick();
        kmac_done = 1'b0;
        tick();
        check("mid_word1", {top_state, hash_msg}, {3'd2, 64'h2});
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", flags(), 9'b100000000);
        check("mid_rst_state", top_state, 3'd0);
        check("mid_rst_mac", mac_out, 256'h0);
        check("mid_rst_msg", hash_msg, 64'h0);
        tick();
        rst_n = 1'b1; req_valid = 1'b1; req_mode = 2'd3;
        tick();
        req_valid = 1'b0;
        check("mid_accept", {op_err, op_done}, 2'b10);
        tick();
        check("mid_no_done", op_done, 1'b0);

        // Single-word chain on the 64-bit instance
        request(2'd2);
        check("w1_start", b_kmac_start, 1'b1);
        kmac_done = 1'b1; kmac_mac = {192'h0, 64'h0123456789ABCDEF};
        tick();
        kmac_done = 1'b0;
        check("w1_state", b_top_state, 3'd2);
        check("w1_word", {b_hash_msg_valid, b_hash_msg_start, b_hash_msg_last, b_hash_msg},
              {3'b111, 64'h0123456789ABCDEF});
        tick();
        check("w1_wait", {b_top_state, b_hash_msg_valid}, {3'd4, 1'b0});
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        tick();
        check("w1_op_done", b_op_done, 1'b1);
        check("w1_mac", b_mac_out, 64'h0123456789ABCDEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
